lap_playback: RTL and testbench
===============================

Name: lap_playback

Overview:
- Stores lap times pushed by the stopwatch control path in a small circular buffer.
- Plays the stored laps back on the four seven-segment digits, one lap per read strobe, oldest first.
- Is the reader end of the stopwatch's lap write path. It consumes the FSM's write, read and clear strobes plus the 1 Hz secpulse from the clock divider.

Parameters:
- DEPTH, 8: number of lap entries stored. Must be a power of two, at least 2.
- DWELL_SEC, 5: number of secpulse ticks with no read before playback ends and the display blanks.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- write  input  1  single-cycle strobe; store lap_time as a new entry
- lap_time  input  16  four BCD digits: [15:12] digit3 … [3:0] digit0
- read  input  1  single-cycle strobe; show next stored lap
- clear  input  1  single-cycle strobe; empty buffer, end playback
- secpulse  input  1  single-cycle 1 Hz tick
- seg0..seg3  output  7 each  segments for digit0..digit3; active-high, bit order gfedcba
- playing  output  1  high while a lap or empty indication is displayed
- lap_index  output  3 ($clog2(DEPTH))  logical index of the displayed lap; 0 = oldest
- count  output  4 ($clog2(DEPTH)+1)  number of valid entries, 0..DEPTH
- full  output  1  count == DEPTH

Behaviour:
- Reset (nrst low, asynchronous) values:
  - seg0..seg3 = 7'h00, playing = 0, lap_index = 0, count = 0, full = 0.
  - Head and tail pointers = 0, state = IDLE, dwell counter = 0.
  - Buffer contents are don't-care.
- Write:
  - Entry stored at head; head advances modulo DEPTH.
  - If count < DEPTH, count increments.
  - If full, the oldest entry is overwritten: tail advances with head and count stays DEPTH.
- Display digits are latched at each read. Later writes or overwrites do not change the display until the next read.
- States:
  - IDLE: all segments off, playing = 0.
    - read with count > 0 → SHOW: latch entry at tail (lap_index = 0).
    - read with count == 0 → EMPTY: all four digits show dash 7'h40.
  - SHOW: playing = 1.
    - read → lap_index increments; wraps to 0 after count-1. Latch that entry.
    - DWELL_SEC consecutive secpulses with no read → IDLE.
  - EMPTY: playing = 1, dashes shown.
    - read restarts the dwell count. If count > 0 by then, go to SHOW at index 0 instead.
    - Dwell expiry → IDLE.
- Dwell counter:
  - Cleared on every state entry and on every read.
  - Increments on each secpulse in SHOW or EMPTY.
  - The transition to IDLE happens on the cycle the DWELL_SEC-th secpulse is sampled.
- Latency: read sampled at edge N → seg, lap_index and playing valid after edge N+1. Outputs are registered.
- Simultaneous events:
  - clear has priority over write and read in the same cycle. Result: count = 0, pointers = 0, state = IDLE, outputs blanked next cycle.
  - write + read in the same cycle: read selects using the pre-write count and tail. The write then takes effect. If full, a same-cycle write does not change which entry the read latches.
  - read + secpulse in the same cycle: read wins and the dwell count is cleared.
- BCD digit decode:
  - 0–9 use standard patterns, e.g. 0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F.
  - Any digit value 10–15 shows dash 7'h40.
- Widths: count is one bit wider than the pointers; pointers wrap naturally at DEPTH.

Decomposition:
- Package lap_pkg holds:
  - the state enum (IDLE, SHOW, EMPTY);
  - the constants SEG_BLANK = 7'h00 and SEG_DASH = 7'h40;
  - the BCD-to-segment lookup function.
- One natural sub-module: bcd_to_seg. It is combinational, 4-bit in and 7-bit out, and is instantiated four times on the latched digits. Its outputs are registered in lap_playback.

Test Plan:
- Reset then read with no writes → EMPTY; seg0..3 = 7'h40 and playing = 1 on the cycle after read. After 5 secpulses → all seg = 7'h00, playing = 0.
- Write 16'h0123 then 16'h0456, then read, read, read → displays 0123 (seg3..seg0 = 3F,06,5B,4F), then 0456, then 0123 again. lap_index goes 0,1,0.
- Write 9 laps 16'h0001..16'h0009 with DEPTH = 8 → count = 8 and full = 1. The first read shows 0002 and the eighth read shows 0009.
- While SHOW displays 0002 and the buffer is full, write 16'h0777 → display stays 0002. The next read shows the next entry, 0004, because 0003 is now the oldest.
- Same-cycle clear + write + read → next cycle count = 0, playing = 0, all seg = 7'h00.
- Digit value 16'h00A5 written then read → seg2..seg3 = 3F, seg1 = 7'h40, seg0 = 6D. Deassert nrst mid-SHOW → outputs are zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lap_pkg.sv
// Shared definitions for the lap playback block: playback state encoding,
// fixed segment patterns and the BCD-to-seven-segment lookup.
// Segment vectors are active-high, bit order gfedcba.
package lap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    EMPTY
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Decimal digits map to their usual glyphs; any non-decimal code shows a dash.
  function automatic logic [6:0] bcd_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/lap_playback_bcd_to_seg.sv
// Combinational BCD digit to seven-segment decoder.
//   digit : 4-bit BCD code (10..15 render as a dash)
//   seg   : segments, active-high, gfedcba
module bcd_to_seg
  import lap_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = bcd_seg(digit);
  end

endmodule

// File: rtl/lap_playback.sv
// Lap time circular buffer with read-strobe playback on four 7-segment digits.
//   clk, nrst        : clock, asynchronous active-low reset
//   write, lap_time  : store a 4-digit BCD lap (overwrites oldest when full)
//   read             : show next stored lap, oldest first
//   clear            : empty the buffer and end playback (highest priority)
//   secpulse         : 1 Hz tick driving the playback dwell timeout
//   seg0..seg3       : registered segments for digit0..digit3 (gfedcba)
//   playing          : a lap or the empty indication is on the display
//   lap_index        : logical index of the shown lap, 0 = oldest
//   count, full      : number of stored laps, count == DEPTH
module lap_playback
  import lap_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DWELL_SEC = 5
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     write,
  input  logic [15:0]              lap_time,
  input  logic                     read,
  input  logic                     clear,
  input  logic                     secpulse,
  output logic [6:0]               seg0,
  output logic [6:0]               seg1,
  output logic [6:0]               seg2,
  output logic [6:0]               seg3,
  output logic                     playing,
  output logic [$clog2(DEPTH)-1:0] lap_index,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(DWELL_SEC + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef logic [DW-1:0] dwell_t;

  localparam cnt_t   CNT_FULL   = cnt_t'(DEPTH);
  localparam dwell_t DWELL_LAST = dwell_t'(DWELL_SEC - 1);

  logic [15:0] mem [DEPTH];
  ptr_t        head;
  ptr_t        tail;
  cnt_t        cnt;

  state_t      state;
  state_t      nxt;
  ptr_t        idx;
  ptr_t        sel_idx;
  ptr_t        rd_addr;
  dwell_t      dwell;
  logic        latch;
  logic        dwell_clr;
  logic        dwell_inc;
  logic [15:0] digits;

  logic [6:0]  dec0;
  logic [6:0]  dec1;
  logic [6:0]  dec2;
  logic [6:0]  dec3;

  // ---------------------------------------------------------------------
  // Playback FSM: next state, dwell control and entry selection.
  // Selection uses the pre-write count and tail, so a same-cycle write
  // never shifts what the read picks up.
  // ---------------------------------------------------------------------
  always_comb begin
    nxt       = state;
    latch     = 1'b0;
    sel_idx   = idx;
    dwell_clr = 1'b0;
    dwell_inc = 1'b0;

    if (clear) begin
      nxt       = IDLE;
      dwell_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (read) begin
            dwell_clr = 1'b1;
            if (cnt != '0) begin
              nxt     = SHOW;
              latch   = 1'b1;
              sel_idx = '0;
            end else begin
              nxt = EMPTY;
            end
          end
        end

        SHOW: begin
          if (read) begin
            dwell_clr = 1'b1;
            latch     = 1'b1;
            sel_idx   = (cnt_t'(idx) + cnt_t'(1) >= cnt) ? '0 : idx + ptr_t'(1);
          end else if (secpulse) begin
            if (dwell == DWELL_LAST) begin
              nxt       = IDLE;
              dwell_clr = 1'b1;
            end else begin
              dwell_inc = 1'b1;
            end
          end
        end

        EMPTY: begin
          if (read) begin
            dwell_clr = 1'b1;
            if (cnt != '0) begin
              nxt     = SHOW;
              latch   = 1'b1;
              sel_idx = '0;
            end
          end else if (secpulse) begin
            if (dwell == DWELL_LAST) begin
              nxt       = IDLE;
              dwell_clr = 1'b1;
            end else begin
              dwell_inc = 1'b1;
            end
          end
        end

        default: begin
          nxt = IDLE;
        end
      endcase
    end
  end

  // Logical index is relative to the oldest entry; pointer width wraps it.
  always_comb begin
    rd_addr = tail + sel_idx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dwell  <= '0;
      idx    <= '0;
      digits <= '0;
    end else begin
      if (dwell_clr) begin
        dwell <= '0;
      end else if (dwell_inc) begin
        dwell <= dwell + dwell_t'(1);
      end

      if (clear) begin
        idx <= '0;
      end else if (latch) begin
        idx    <= sel_idx;
        digits <= mem[rd_addr];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Circular buffer: a write when full drags the tail along with the head.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (write) begin
      head <= head + ptr_t'(1);
      if (cnt == CNT_FULL) begin
        tail <= tail + ptr_t'(1);
      end else begin
        cnt <= cnt + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write && !clear) begin
      mem[head] <= lap_time;
    end
  end

  // ---------------------------------------------------------------------
  // Display path: decode latched digits, then register all outputs.
  // ---------------------------------------------------------------------
  bcd_to_seg u_dig0 (.digit(digits[3:0]),   .seg(dec0));
  bcd_to_seg u_dig1 (.digit(digits[7:4]),   .seg(dec1));
  bcd_to_seg u_dig2 (.digit(digits[11:8]),  .seg(dec2));
  bcd_to_seg u_dig3 (.digit(digits[15:12]), .seg(dec3));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg0      <= SEG_BLANK;
      seg1      <= SEG_BLANK;
      seg2      <= SEG_BLANK;
      seg3      <= SEG_BLANK;
      playing   <= 1'b0;
      lap_index <= '0;
    end else begin
      unique case (state)
        SHOW: begin
          seg0 <= dec0;
          seg1 <= dec1;
          seg2 <= dec2;
          seg3 <= dec3;
        end
        EMPTY: begin
          seg0 <= SEG_DASH;
          seg1 <= SEG_DASH;
          seg2 <= SEG_DASH;
          seg3 <= SEG_DASH;
        end
        default: begin
          seg0 <= SEG_BLANK;
          seg1 <= SEG_BLANK;
          seg2 <= SEG_BLANK;
          seg3 <= SEG_BLANK;
        end
      endcase
      playing   <= (state != IDLE);
      lap_index <= (state == SHOW) ? idx : '0;
    end
  end

  always_comb begin
    count = cnt;
    full  = (cnt == CNT_FULL);
  end

endmodule

// File: tb/tb_lap_playback.sv
// Self-checking bench for lap_playback: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_lap_playback;

  localparam int DEPTH = 8;
  localparam int DWELL = 5;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_EMPTY = 2;

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        write = 1'b0;
  logic [15:0] lap_time = '0;
  logic        read = 1'b0;
  logic        clear = 1'b0;
  logic        secpulse = 1'b0;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        playing;
  logic [2:0]  lap_index;
  logic [3:0]  count;
  logic        full;
  logic [27:0] segs;

  int checks = 0;
  int errors = 0;

  lap_playback #(.DEPTH(DEPTH), .DWELL_SEC(DWELL)) dut (
    .clk(clk), .nrst(nrst), .write(write), .lap_time(lap_time), .read(read),
    .clear(clear), .secpulse(secpulse), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .seg3(seg3), .playing(playing), .lap_index(lap_index), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  assign segs = {seg3, seg2, seg1, seg0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    return (d < 10) ? PAT[d] : 7'h40;
  endfunction

  function automatic logic [27:0] ref_disp(input logic [15:0] v);
    return {ref_seg(v[15:12]), ref_seg(v[11:8]), ref_seg(v[7:4]), ref_seg(v[3:0])};
  endfunction

  // Reference model: laps as a bounded queue, oldest at the front.
  logic [15:0] q [$];
  int          m_state = M_IDLE;
  int          m_idx   = 0;
  int          m_dwell = 0;
  logic [15:0] m_disp  = '0;
  logic [27:0] e_segs  = '0;
  logic        e_play  = 1'b0;
  logic [2:0]  e_idx   = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.delete();
      m_state = M_IDLE;
      m_idx   = 0;
      m_dwell = 0;
      e_segs  = '0;
      e_play  = 1'b0;
      e_idx   = '0;
    end else begin
      // What the display shows after this edge reflects the state held before it.
      e_play = (m_state != M_IDLE);
      e_idx  = (m_state == M_SHOW) ? 3'(m_idx) : 3'd0;
      if (m_state == M_SHOW)       e_segs = ref_disp(m_disp);
      else if (m_state == M_EMPTY) e_segs = {4{7'h40}};
      else                         e_segs = '0;

      if (clear) begin
        q.delete();
        m_state = M_IDLE;
        m_idx   = 0;
        m_dwell = 0;
      end else begin
        if (read) begin
          m_dwell = 0;
          if (m_state == M_SHOW) begin
            m_idx  = (m_idx + 1 >= q.size()) ? 0 : m_idx + 1;
            m_disp = q[m_idx];
          end else if (q.size() > 0) begin
            m_state = M_SHOW;
            m_idx   = 0;
            m_disp  = q[0];
          end else begin
            m_state = M_EMPTY;
          end
        end else if (secpulse && m_state != M_IDLE) begin
          m_dwell++;
          if (m_dwell == DWELL) begin
            m_state = M_IDLE;
            m_dwell = 0;
          end
        end
        if (write) begin
          q.push_back(lap_time);
          if (q.size() > DEPTH) void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      check("cmp_segs",  segs,      e_segs);
      check("cmp_play",  playing,   e_play);
      check("cmp_idx",   lap_index, e_idx);
      check("cmp_count", count,     q.size());
      check("cmp_full",  full,      q.size() == DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] v);
    lap_time = v;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read();
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic do_sec();
    secpulse = 1'b1;
    tick();
    secpulse = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    nrst = 1'b1;
    check("reset_segs",  segs, 0);
    check("reset_play",  playing, 0);
    check("reset_idx",   lap_index, 0);
    check("reset_count", count, 0);
    check("reset_full",  full, 0);

    // Read with an empty buffer: dashes, then dwell timeout.
    do_read();
    tick();
    check("empty_dash", segs, {4{7'h40}});
    check("empty_play", playing, 1);
    repeat (4) do_sec();
    tick();
    check("empty_4sec_play", playing, 1);
    do_sec();
    tick();
    check("empty_timeout_segs", segs, 0);
    check("empty_timeout_play", playing, 0);

    // Two laps, cycled through.
    do_write(16'h0123);
    do_write(16'h0456);
    do_read();
    tick();
    check("show_0123", segs, {7'h3F, 7'h06, 7'h5B, 7'h4F});
    check("show_0123_idx", lap_index, 0);
    check("two_count", count, 2);
    do_read();
    tick();
    check("show_0456", segs, {7'h3F, 7'h66, 7'h6D, 7'h7D});
    check("show_0456_idx", lap_index, 1);
    do_read();
    tick();
    check("wrap_0123", segs, {7'h3F, 7'h06, 7'h5B, 7'h4F});
    check("wrap_0123_idx", lap_index, 0);
    do_clear();
    tick();

    // Overfill: oldest lap is dropped.
    for (int v = 1; v <= 9; v++) do_write(16'(v));
    check("full_count", count, 8);
    check("full_flag", full, 1);
    do_read();
    tick();
    check("first_0002", segs, {7'h3F, 7'h3F, 7'h3F, 7'h5B});
    for (int i = 0; i < 6; i++) do_read();
    do_read();
    tick();
    check("eighth_0009", segs, {7'h3F, 7'h3F, 7'h3F, 7'h6F});
    check("eighth_idx", lap_index, 7);
    do_read();
    tick();
    check("wrap_0002", segs, {7'h3F, 7'h3F, 7'h3F, 7'h5B});
    do_write(16'h0777);
    tick();
    check("hold_0002", segs, {7'h3F, 7'h3F, 7'h3F, 7'h5B});
    check("hold_count", count, 8);
    do_read();
    tick();
    check("next_0004", segs, {7'h3F, 7'h3F, 7'h3F, 7'h66});
    check("next_0004_idx", lap_index, 1);

    // Clear beats write and read.
    clear = 1'b1; write = 1'b1; read = 1'b1; lap_time = 16'h1234;
    tick();
    clear = 1'b0; write = 1'b0; read = 1'b0;
    tick();
    check("clr_count", count, 0);
    check("clr_play", playing, 0);
    check("clr_segs", segs, 0);

    // Non-decimal digit, then asynchronous reset mid-show.
    do_write(16'h00A5);
    do_read();
    tick();
    check("hex_digit", segs, {7'h3F, 7'h3F, 7'h40, 7'h6D});
    #2 nrst = 1'b0;
    #1;
    check("async_segs", segs, 0);
    check("async_play", playing, 0);
    check("async_count", count, 0);
    check("async_idx", lap_index, 0);
    tick();
    nrst = 1'b1;

    // Write and read together while full: read takes the pre-write oldest.
    for (int v = 8'h11; v <= 8'h18; v++) do_write(16'(v));
    lap_time = 16'h0019; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    tick();
    check("wr_rd_0011", segs, {7'h3F, 7'h3F, 7'h06, 7'h06});
    do_read();
    tick();
    check("after_ovw_0013", segs, {7'h3F, 7'h3F, 7'h06, 7'h4F});

    // Read coinciding with a secpulse restarts the dwell.
    repeat (4) do_sec();
    read = 1'b1; secpulse = 1'b1;
    tick();
    read = 1'b0; secpulse = 1'b0;
    repeat (4) do_sec();
    tick();
    check("rd_sec_play", playing, 1);
    do_sec();
    tick();
    check("rd_sec_timeout", playing, 0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 400; i++) begin
      write    = ($urandom_range(0, 2) == 0);
      lap_time = 16'($urandom);
      read     = ($urandom_range(0, 3) == 0);
      secpulse = ($urandom_range(0, 4) == 0);
      clear    = ($urandom_range(0, 59) == 0);
      tick();
    end
    write = 1'b0; read = 1'b0; secpulse = 1'b0; clear = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
